vector_nibble_serializer: RTL and testbench
===========================================

// Module: vector_nibble_serializer
// PURPOSE
//   Downstream stage of the 36-bit vector-combination logic. Captures one
//   NIBBLES*NIB_W result word per valid/ready handshake. Emits it nibble by
//   nibble, LSB nibble first (nibble 0 = bits [3:0]), on a 4-bit valid/ready
//   stream. Each nibble is one INV/INV/INV/OAI222 output group, so a
//   downstream checker sees the results one group at a time.
// PARAMETERS
//   NIBBLES  9   nibbles per input word (one per gate group)
//   NIB_W    4   bits per nibble
//   CNT_W    16  width of completed-word counter
// PORTS
//   clk        in   1                 single clock, rising edge
//   rst        in   1                 asynchronous, active-high reset
//   in_valid   in   1                 input word valid
//   in_ready   out  1                 input word accepted when valid&ready
//   in_data    in   NIBBLES*NIB_W     result word
//   out_valid  out  1                 nibble valid
//   out_ready  in   1                 sink accepts nibble
//   out_nib    out  NIB_W             current nibble
//   out_idx    out  $clog2(NIBBLES)   index of current nibble (0..NIBBLES-1)
//   out_last   out  1                 out_idx == NIBBLES-1
//   word_cnt   out  CNT_W             words fully drained; wraps to 0 at max
// BEHAVIOUR
//   - Reset (async assert, sync release), all outputs and state:
//     state=IDLE, out_valid=0, out_nib=0, out_idx=0, word reg=0, word_cnt=0.
//     Reset mid-word discards the word. No partial output after release.
//   - FSM states:
//     - IDLE: in_ready=1, out_valid=0. If in_valid, latch in_data, idx=0,
//       then go to SHIFT.
//     - SHIFT: out_valid=1, out_nib=word[idx*NIB_W +: NIB_W]. If out_ready
//       and not last, idx++. If out_ready and last, word_cnt++, then:
//       if in_valid, latch the new word, idx=0, stay in SHIFT;
//       else go to IDLE.
//   - in_ready = (state==IDLE) | (state==SHIFT & out_last & out_ready). This
//     is a combinational path from out_ready and is allowed. It gives
//     back-to-back words with no bubble: NIBBLES beats per word.
//   - Latency: word accepted on edge N drives nibble 0 valid after edge N.
//   - out_nib, out_idx and out_last are stable while out_valid & !out_ready.
//     in_data is ignored unless in_valid & in_ready.
//   - word_cnt: CNT_W-bit unsigned. It wraps from 2^CNT_W-1 to 0 silently.
// CONFIGURATION
//   VEC_SER_PARITY_EN defined: adds output port out_par (1 bit).
//     out_par = odd parity of out_nib (~^out_nib), registered with the nibble.
//     Reset value 1 (odd parity of 0).
//   VEC_SER_PARITY_EN undefined: the out_par port and its logic do not exist.
//     All other behaviour is identical.
// STRUCTURE
//   Package vec_ser_pkg:
//     - typedef enum logic {IDLE, SHIFT} vec_ser_state_t
//     - localparam IDX_W helper function
//     - default NIB_W
//   Sub-module vec_ser_nib_mux: combinational NIBBLES:1 nibble selector,
//   word + idx -> nibble. The top level holds the FSM, registers and counter.
// TESTING
//   1. Reset:
//      - Stimulus: rst pulsed mid-SHIFT with idx=4.
//      - Required: out_valid=0, out_idx=0, word_cnt=0 immediately (async).
//        in_ready=1 after release.
//   2. Single word:
//      - Stimulus: in_data=36'h8_7654_3210, out_ready held 1.
//      - Required: nibbles 0,1,2,...,8 on 9 consecutive cycles.
//        out_last on beat 9 only. word_cnt=1.
//   3. Back-to-back:
//      - Stimulus: two words offered continuously.
//      - Required: in_ready high on the last beat of word 1. 18 beats with
//        no gap. word_cnt=2.
//   4. Backpressure:
//      - Stimulus: out_ready toggled 1,0,0,1 during word 36'hF_FFFF_FFFF.
//      - Required: out_nib/out_idx held during stalls. No nibble lost or
//        duplicated.
//   5. Counter wrap:
//      - Stimulus: CNT_W=2, 5 words.
//      - Required: word_cnt goes 1,2,3,0,1.
//   6. Parity (VEC_SER_PARITY_EN defined):
//      - Stimulus: nibble 4'h3.
//      - Required: out_par=1. Nibble 4'h7 gives out_par=0.

Source files
------------

// File: rtl/vec_ser_pkg.sv
// Shared types and sizing helpers for the vector nibble serializer.
package vec_ser_pkg;

  typedef enum logic {IDLE, SHIFT} vec_ser_state_t;

  localparam int unsigned NIB_W_DEF = 4;

  // Index width for n nibbles; a single-nibble word still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vec_ser_nib_mux.sv
// Combinational NIBBLES:1 selector: picks word[idx*NIB_W +: NIB_W].
module vec_ser_nib_mux #(
  parameter int unsigned NIBBLES = 9,
  parameter int unsigned NIB_W   = 4,
  parameter int unsigned IDX_W   = 4
) (
  input  logic [NIBBLES*NIB_W-1:0] word_i,
  input  logic [IDX_W-1:0]         idx_i,
  output logic [NIB_W-1:0]         nib_o
);

  // Out-of-range indices yield zero rather than an X slice.
  always_comb begin
    nib_o = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_i == IDX_W'(i)) nib_o = word_i[i*NIB_W +: NIB_W];
    end
  end

endmodule

// File: rtl/vector_nibble_serializer.sv
// Captures one result word per handshake and streams it LSB nibble first.
// Optional odd-parity output out_par is enabled by defining VEC_SER_PARITY_EN.
module vector_nibble_serializer
  import vec_ser_pkg::*;
#(
  parameter  int unsigned NIBBLES = 9,
  parameter  int unsigned NIB_W   = NIB_W_DEF,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned IDX_W   = idx_w(NIBBLES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NIBBLES*NIB_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NIB_W-1:0]         out_nib,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_last,
`ifdef VEC_SER_PARITY_EN
  output logic                     out_par,
`endif
  output logic [CNT_W-1:0]         word_cnt
);

  vec_ser_state_t           state_q, state_d;
  logic [NIBBLES*NIB_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_last = (state_q == SHIFT) && (idx_q == IDX_W'(NIBBLES - 1));

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d  = in_data;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (!out_last) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            // Last beat doubles as an accept slot so words stream with no bubble.
            in_ready = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
            idx_d    = '0;
            if (in_valid) begin
              word_d = in_data;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  vec_ser_nib_mux #(
    .NIBBLES (NIBBLES),
    .NIB_W   (NIB_W),
    .IDX_W   (IDX_W)
  ) u_nib_mux (
    .word_i (word_q),
    .idx_i  (idx_q),
    .nib_o  (out_nib)
  );

`ifdef VEC_SER_PARITY_EN
  logic [NIB_W-1:0] nib_d;
  logic             par_q;

  // Parity is computed from the next word/index so it updates on the same edge as the nibble.
  vec_ser_nib_mux #(
    .NIBBLES (NIBBLES),
    .NIB_W   (NIB_W),
    .IDX_W   (IDX_W)
  ) u_par_mux (
    .word_i (word_d),
    .idx_i  (idx_d),
    .nib_o  (nib_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b1;
    else     par_q <= ~^nib_d;
  end

  assign out_par = par_q;
`endif

  assign out_idx  = idx_q;
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_vector_nibble_serializer.sv
// Directed self-checking bench for vector_nibble_serializer (default and CNT_W=2 instances).
module tb_vector_nibble_serializer;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [35:0] in_data;
  logic [3:0]  out_nib, out_idx;
  logic [15:0] word_cnt;
`ifdef VEC_SER_PARITY_EN
  logic        out_par;
  logic        w_out_par;
`endif

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_last;
  logic [35:0] w_in_data;
  logic [3:0]  w_out_nib, w_out_idx;
  logic [1:0]  w_word_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vector_nibble_serializer #(.NIBBLES(9), .NIB_W(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_nib   (out_nib),
    .out_idx   (out_idx),
    .out_last  (out_last),
`ifdef VEC_SER_PARITY_EN
    .out_par   (out_par),
`endif
    .word_cnt  (word_cnt)
  );

  vector_nibble_serializer #(.NIBBLES(9), .NIB_W(4), .CNT_W(2)) u_wrap (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_data   (w_in_data),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .out_nib   (w_out_nib),
    .out_idx   (w_out_idx),
    .out_last  (w_out_last),
`ifdef VEC_SER_PARITY_EN
    .out_par   (w_out_par),
`endif
    .word_cnt  (w_word_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    checks++; if (out_idx !== 4'd0) begin errors++; $display("FAIL rst_idx got %0d exp 0", out_idx); end
    checks++; if (out_nib !== 4'd0) begin errors++; $display("FAIL rst_nib got %h exp 0", out_nib); end
    checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", word_cnt); end
`ifdef VEC_SER_PARITY_EN
    checks++; if (out_par !== 1'b1) begin errors++; $display("FAIL rst_par got %b exp 1", out_par); end
`endif
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_single_word();
    in_data   = 36'h8_7654_3210;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid beat %0d got %b exp 1", k, out_valid); end
      checks++; if (out_nib !== 4'(k)) begin errors++; $display("FAIL single_nib beat %0d got %h exp %h", k, out_nib, 4'(k)); end
      checks++; if (out_idx !== 4'(k)) begin errors++; $display("FAIL single_idx beat %0d got %0d exp %0d", k, out_idx, k); end
      checks++; if (out_last !== (k == 8)) begin errors++; $display("FAIL single_last beat %0d got %b exp %b", k, out_last, (k == 8)); end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_done_valid got %b exp 0", out_valid); end
    checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", word_cnt); end
  endtask

  task automatic test_reset_mid();
    in_data   = 36'h0_ABCD_EF98;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    checks++; if (out_idx !== 4'd4) begin errors++; $display("FAIL midrst_pre_idx got %0d exp 4", out_idx); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", out_valid); end
    checks++; if (out_idx !== 4'd0) begin errors++; $display("FAIL midrst_idx got %0d exp 0", out_idx); end
    checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt got %0d exp 0", word_cnt); end
    checks++; if (out_nib !== 4'd0) begin errors++; $display("FAIL midrst_nib got %h exp 0", out_nib); end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_partial got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_nib;
    in_data   = 36'h8_7654_3210;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_data = 36'h0_1234_5678;
    for (int b = 0; b < 18; b++) begin
      exp_nib = (b < 9) ? 4'(b) : 4'(17 - b);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid beat %0d got %b exp 1", b, out_valid); end
      checks++; if (out_nib !== exp_nib) begin errors++; $display("FAIL b2b_nib beat %0d got %h exp %h", b, out_nib, exp_nib); end
      if (b <= 8) begin
        checks++; if (in_ready !== (b == 8)) begin errors++; $display("FAIL b2b_ready beat %0d got %b exp %b", b, in_ready, (b == 8)); end
      end
      step();
      if (b == 8) in_valid = 1'b0;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_done_valid got %b exp 0", out_valid); end
    checks++; if (word_cnt !== 16'd2) begin errors++; $display("FAIL b2b_cnt got %0d exp 2", word_cnt); end
  endtask

  task automatic test_backpressure();
    logic [12:0] pat;
    int          exp_idx;
    int          beats;
    pat       = 13'b1101111011001; // bit c is out_ready in cycle c
    exp_idx   = 0;
    beats     = 0;
    in_data   = 36'hF_FFFF_FFFF;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 13; c++) begin
      out_ready = pat[c];
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc %0d got %b exp 1", c, out_valid); end
      checks++; if (out_idx !== 4'(exp_idx)) begin errors++; $display("FAIL bp_idx cyc %0d got %0d exp %0d", c, out_idx, exp_idx); end
      checks++; if (out_nib !== 4'hF) begin errors++; $display("FAIL bp_nib cyc %0d got %h exp f", c, out_nib); end
      if (pat[c]) begin
        beats++;
        exp_idx++;
      end
      step();
    end
    out_ready = 1'b1;
    checks++; if (beats !== 9) begin errors++; $display("FAIL bp_beats got %0d exp 9", beats); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_done_valid got %b exp 0", out_valid); end
    checks++; if (word_cnt !== 16'd3) begin errors++; $display("FAIL bp_cnt got %0d exp 3", word_cnt); end
  endtask

  task automatic test_counter_wrap();
    int wait_cyc;
    w_in_data   = 36'h5_A5A5_A5A5;
    w_in_valid  = 1'b1;
    w_out_ready = 1'b1;
    step();
    for (int w = 0; w < 5; w++) begin
      wait_cyc = 0;
      while (!(w_out_valid === 1'b1 && w_out_last === 1'b1) && wait_cyc < 20) begin
        step();
        wait_cyc++;
      end
      if (wait_cyc >= 20) begin
        checks++; errors++;
        $display("FAIL wrap_timeout word %0d got no last beat exp one within 20 cycles", w);
      end
      if (w == 4) w_in_valid = 1'b0;
      step();
      checks++; if (w_word_cnt !== 2'((w + 1) % 4)) begin errors++; $display("FAIL wrap_cnt word %0d got %0d exp %0d", w, w_word_cnt, (w + 1) % 4); end
    end
  endtask

`ifdef VEC_SER_PARITY_EN
  task automatic test_parity();
    in_data   = 36'h0_0000_0073;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    checks++; if (out_par !== 1'b1) begin errors++; $display("FAIL par_nib3 got %b exp 1", out_par); end
    out_ready = 1'b1;
    step();
    checks++; if (out_nib !== 4'h7) begin errors++; $display("FAIL par_nib got %h exp 7", out_nib); end
    checks++; if (out_par !== 1'b0) begin errors++; $display("FAIL par_nib7 got %b exp 0", out_par); end
    step();
    checks++; if (out_par !== 1'b1) begin errors++; $display("FAIL par_nib0 got %b exp 1", out_par); end
    repeat (8) step();
  endtask
`endif

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    w_in_valid  = 1'b0;
    w_in_data   = '0;
    w_out_ready = 1'b0;
    test_reset();
    test_single_word();
    test_reset_mid();
    test_back_to_back();
    test_backpressure();
    test_counter_wrap();
`ifdef VEC_SER_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
